// File: rtl/alu_exec_unit_if.sv
// Handshake bundle for the execute-stage ALU: request side (operands, op code)
// and response side (registered result, status).
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, alu_ctrl, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_ctrl, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Sequential execute-stage ALU: single-cycle ops plus an iterative shift-add
// multiplier, with valid/ready handshakes on both sides.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic          clk,
  input logic          rst_n,
  alu_exec_unit_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [XLEN-1:0] result_r, result_s;
  logic            out_valid_r, out_valid_s;
  logic [XLEN-1:0] acc_r, acc_s;
  logic [XLEN-1:0] mcand_r, mcand_s;
  logic [XLEN-1:0] mplier_r, mplier_s;
  logic [SHW-1:0]  cnt_r, cnt_s;
  logic [XLEN-1:0] acc_sum_s;
  logic            in_ready_s;
  logic            accept_s;

  // MUL is not handled here; reserved codes (and MUL) fall through to zero.
  function automatic logic [XLEN-1:0] alu_f(
    input logic [3:0]      op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return $unsigned($signed(a) >>> sh);
      OP_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      default: return {XLEN{1'b0}};
    endcase
  endfunction

  assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign acc_sum_s  = acc_r + (mplier_r[0] ? mcand_r : {XLEN{1'b0}});

  // Next-state and datapath update for the IDLE/MUL controller.
  always_comb begin
    state_s     = state_r;
    result_s    = result_r;
    out_valid_s = out_valid_r;
    acc_s       = acc_r;
    mcand_s     = mcand_r;
    mplier_s    = mplier_r;
    cnt_s       = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.alu_ctrl == OP_MUL) begin
            mcand_s     = bus.src_a;
            mplier_s    = bus.src_b;
            acc_s       = {XLEN{1'b0}};
            cnt_s       = {SHW{1'b0}};
            out_valid_s = 1'b0;
            state_s     = ST_MUL;
          end else begin
            result_s    = alu_f(bus.alu_ctrl, bus.src_a, bus.src_b);
            out_valid_s = 1'b1;
          end
        end else if (bus.out_ready) begin
          out_valid_s = 1'b0;
        end else begin
          out_valid_s = out_valid_r;
        end
      end
      ST_MUL: begin
        acc_s    = acc_sum_s;
        mcand_s  = mcand_r << 1;
        mplier_s = mplier_r >> 1;
        cnt_s    = cnt_r + {{(SHW-1){1'b0}}, 1'b1};
        // Fixed latency: the XLEN-th iteration writes the product out.
        if (cnt_r == SHW'(XLEN - 1)) begin
          result_s    = acc_sum_s;
          out_valid_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s     = ST_MUL;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; async reset discards any in-flight MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      result_r    <= {XLEN{1'b0}};
      out_valid_r <= 1'b0;
      acc_r       <= {XLEN{1'b0}};
      mcand_r     <= {XLEN{1'b0}};
      mplier_r    <= {XLEN{1'b0}};
      cnt_r       <= {SHW{1'b0}};
    end else begin
      state_r     <= state_s;
      result_r    <= result_s;
      out_valid_r <= out_valid_s;
      acc_r       <= acc_s;
      mcand_r     <= mcand_s;
      mplier_r    <= mplier_s;
      cnt_r       <= cnt_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = (result_r == {XLEN{1'b0}});
  assign bus.busy      = (state_r == ST_MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: inputs change and outputs are
// checked on the falling clock edge.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  alu_exec_unit_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.alu_ctrl = op;
    bus.src_a    = a;
    bus.src_b    = b;
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    tests_run++;
    if (bus.result !== 32'h0) begin tests_failed++; $display("FAIL reset_result got %h exp 0", bus.result); end
    tests_run++;
    if (bus.zero !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_flags got zero=%b busy=%b in_ready=%b exp 1/0/1", bus.zero, bus.busy, bus.in_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_sub();
    bus.out_ready = 1'b1;
    drive(1'b1, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    step();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h8000_0000 || bus.zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_wrap got v=%b r=%h z=%b exp 1/80000000/0", bus.out_valid, bus.result, bus.zero);
    end
    drive(1'b1, 4'b0001, 32'd5, 32'd5);
    step();
    tests_run++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub_zero got r=%h z=%b exp 0/1", bus.result, bus.zero);
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    step();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL consume_drop got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_shift_cmp();
    logic [3:0]  ops [5];
    logic [31:0] as  [5];
    logic [31:0] bs  [5];
    logic [31:0] exp [5];
    ops[0] = 4'b0111; as[0] = 32'h8000_0000; bs[0] = 32'h0000_0024; exp[0] = 32'hF800_0000;
    ops[1] = 4'b0110; as[1] = 32'h8000_0000; bs[1] = 32'h0000_0024; exp[1] = 32'h0800_0000;
    ops[2] = 4'b1001; as[2] = 32'hFFFF_FFFF; bs[2] = 32'h0000_0001; exp[2] = 32'h0000_0000;
    ops[3] = 4'b1000; as[3] = 32'hFFFF_FFFF; bs[3] = 32'h0000_0001; exp[3] = 32'h0000_0001;
    ops[4] = 4'b1111; as[4] = 32'h1234_5678; bs[4] = 32'h0000_0001; exp[4] = 32'h0000_0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], as[i], bs[i]);
      step();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp[i]) begin
        tests_failed++;
        $display("FAIL shift_cmp[%0d] got v=%b r=%h exp 1/%h", i, bus.out_valid, bus.result, exp[i]);
      end
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_mul();
    int  busy_cnt;
    bit  ir_bad;
    bit  done;
    busy_cnt = 0;
    ir_bad   = 1'b0;
    done     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'b1010, 32'hFFFF_FFFF, 32'h0000_0003);
    step();
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid === 1'b1) begin
        done = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.in_ready !== 1'b0) ir_bad = 1'b1;
      // Requests raised mid-multiply must be ignored.
      drive(k[0], 4'b0000, 32'h1, 32'h1);
      step();
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    tests_run++;
    if (done !== 1'b1 || bus.result !== 32'hFFFF_FFFD) begin
      tests_failed++;
      $display("FAIL mul_result got done=%b r=%h exp 1/fffffffd", done, bus.result);
    end
    tests_run++;
    if (busy_cnt !== 32 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_busy got cycles=%0d busy_now=%b exp 32/0", busy_cnt, bus.busy);
    end
    tests_run++;
    if (ir_bad !== 1'b0) begin tests_failed++; $display("FAIL mul_in_ready got high during MUL exp low"); end
    step();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'hFFFF_FFFD) begin
      tests_failed++;
      $display("FAIL mul_after got v=%b r=%h exp 0/fffffffd", bus.out_valid, bus.result);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 4'b0000, 32'd1, 32'd2);
    step();
    drive(1'b1, 4'b0100, 32'h0000_00F0, 32'h0000_00FF);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd3 || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d] got v=%b r=%h rdy=%b exp 1/3/0", i, bus.out_valid, bus.result, bus.in_ready);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); end
    step();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h0000_000F) begin
      tests_failed++;
      $display("FAIL bp_xor got v=%b r=%h exp 1/0000000f", bus.out_valid, bus.result);
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exp [4];
    ops[0] = 4'b0000; as[0] = 32'd10;        bs[0] = 32'd20;        exp[0] = 32'h0000_001E;
    ops[1] = 4'b0001; as[1] = 32'd100;       bs[1] = 32'd1;         exp[1] = 32'h0000_0063;
    ops[2] = 4'b0011; as[2] = 32'h0000_000F; bs[2] = 32'h0000_00F0; exp[2] = 32'h0000_00FF;
    ops[3] = 4'b0101; as[3] = 32'h0000_0001; bs[3] = 32'd31;        exp[3] = 32'h8000_0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.result !== exp[i-1] || bus.in_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b[%0d] got v=%b r=%h rdy=%b exp 1/%h/1", i-1, bus.out_valid, bus.result, bus.in_ready, exp[i-1]);
        end
      end
      if (i < 4) drive(1'b1, ops[i], as[i], bs[i]);
      else       drive(1'b0, 4'b0000, 32'h0, 32'h0);
      step();
    end
  endtask

  task automatic test_reset_mid_mul();
    bus.out_ready = 1'b1;
    drive(1'b1, 4'b1010, 32'd5, 32'd7);
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) step();
    tests_run++;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL mid_mul_busy got %b exp 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_mul_reset got busy=%b v=%b r=%h z=%b exp 0/0/0/1", bus.busy, bus.out_valid, bus.result, bus.zero);
    end
    step();
    rst_n = 1'b1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready got %b exp 1", bus.in_ready); end
    drive(1'b1, 4'b0000, 32'd2, 32'd2);
    step();
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd4 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_add got v=%b r=%h busy=%b exp 1/4/0", bus.out_valid, bus.result, bus.busy);
    end
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_shift_cmp();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
